// File: rtl/lsu_pkg.sv
// Shared types and defaults for the byte-wide load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_SETUP,
    WR_PULSE,
    RESP
  } lsu_state_t;

  localparam int DEFAULT_READ_LATENCY = 2;
  localparam int DEFAULT_WRITE_SETUP  = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lsu_wait_counter.sv
// Loadable down-counter; o_done is high once the count has drained to zero.
module lsu_wait_counter #(
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/load_store_unit.sv
// Sequences 8/16-bit CPU loads and stores into little-endian byte accesses on
// the shared memory's data port, holding each address across its read/merge path.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
  parameter int WRITE_SETUP  = DEFAULT_WRITE_SETUP
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic        i_req_word,
  input  logic        i_req_signed,
  input  logic [15:0] i_req_addr,
  input  logic [15:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [15:0] o_resp_rdata,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata,
  output logic        o_mem_write
);

  localparam int CNT_W = $clog2(max_int(READ_LATENCY, WRITE_SETUP) + 1);
  // A wait of N cycles loads N-1 so done rises in the Nth cycle of the state.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_SETUP - 1);

  lsu_state_t r_state;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic        r_mem_write;
  logic        r_resp_valid;
  logic [15:0] r_resp_rdata;
  logic [7:0]  r_wdata_hi;
  logic        r_write;
  logic        r_word;
  logic        r_signed;
  logic        r_idx;

  logic             w_accept;
  logic             w_more;
  logic             w_done;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;

  assign o_req_ready = (r_state == IDLE);
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_more      = r_word && !r_idx;

  // Reload on acceptance and whenever the second byte of a word begins.
  assign w_cnt_load = w_accept
                   || ((r_state == RD_WAIT) && w_done && w_more)
                   || ((r_state == WR_PULSE) && w_more);
  assign w_cnt_val  = (w_accept ? i_req_write : r_write) ? WR_LOAD : RD_LOAD;

  lsu_wait_counter #(.WIDTH(CNT_W)) u_wait (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_done     (w_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_write  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_wdata_hi   <= '0;
      r_write      <= 1'b0;
      r_word       <= 1'b0;
      r_signed     <= 1'b0;
      r_idx        <= 1'b0;
    end else begin
      r_mem_write  <= 1'b0;
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_mem_addr   <= i_req_addr;
            r_wdata_hi   <= i_req_wdata[15:8];
            r_write      <= i_req_write;
            r_word       <= i_req_word;
            r_signed     <= i_req_signed;
            r_idx        <= 1'b0;
            r_resp_rdata <= '0;
            if (i_req_write) begin
              r_mem_wdata <= i_req_wdata[7:0];
              r_state     <= WR_SETUP;
            end else begin
              r_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (w_done) begin
            if (!r_word) begin
              r_resp_rdata <= {{8{r_signed & i_mem_rdata[7]}}, i_mem_rdata};
            end else if (!r_idx) begin
              r_resp_rdata[7:0] <= i_mem_rdata;
            end else begin
              r_resp_rdata[15:8] <= i_mem_rdata;
            end
            if (w_more) begin
              r_idx      <= 1'b1;
              r_mem_addr <= r_mem_addr + 16'd1;
            end else begin
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end
          end
        end
        WR_SETUP: begin
          if (w_done) begin
            r_mem_write <= 1'b1;
            r_state     <= WR_PULSE;
          end
        end
        WR_PULSE: begin
          if (w_more) begin
            r_idx       <= 1'b1;
            r_mem_addr  <= r_mem_addr + 16'd1;
            r_mem_wdata <= r_wdata_hi;
            r_state     <= WR_SETUP;
          end else begin
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_write  = r_mem_write;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: a byte-array reference model predicts each response and
// write pulse; a negedge monitor pops and compares against the DUT outputs.
module tb_load_store_unit;

  localparam int RL = 2;
  localparam int WS = 3;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_word = 1'b0;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_write;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  resp_t rq[$];
  wr_t   wq[$];

  logic [7:0] env_mem [0:65535];
  logic [7:0] ref_mem [0:65535];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit #(.READ_LATENCY(RL), .WRITE_SETUP(WS)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_write  (req_write),
    .i_req_word   (req_word),
    .i_req_signed (req_signed),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_mem_write  (mem_write)
  );

  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] v;
    case (i)
      32'h0011: return 8'h80;
      32'h0101: return 8'h34;
      32'h0102: return 8'h12;
      32'h0020: return 8'h66;
      32'h0021: return 8'h55;
      default: begin
        v = (i * 37 + 11) ^ (i >> 8);
        return v[7:0];
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: byte writes on mem_write, one registered read stage.
  initial begin
    for (int i = 0; i < 65536; i++) env_mem[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (mem_write) env_mem[mem_addr] = mem_wdata;
      mem_rdata <= env_mem[mem_addr];
    end
  end

  // Monitor
  initial begin
    resp_t r;
    wr_t   w;
    int    run_len;
    logic [15:0] prev_addr;
    run_len = 0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_len = 0;
        prev_addr = mem_addr;
      end else begin
        run_len = (mem_addr == prev_addr) ? run_len + 1 : 0;
        prev_addr = mem_addr;
        if (resp_valid) begin
          if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_valid with rdata %h, required none (cycle %0d)", resp_rdata, cyc);
          end else begin
            r = rq.pop_front();
            chk("resp_cycle", cyc, r.cyc);
            chk("resp_rdata", resp_rdata, r.data);
            $display("resp  cycle %0d rdata %h", cyc, resp_rdata);
          end
        end
        if (mem_write) begin
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got mem_write at %h, required none (cycle %0d)", mem_addr, cyc);
          end else begin
            w = wq.pop_front();
            chk("write_cycle", cyc, w.cyc);
            chk("write_addr", mem_addr, w.addr);
            chk("write_data", mem_wdata, w.data);
            chk("write_addr_stable", run_len >= WS, 1);
            $display("write cycle %0d addr %h data %h", cyc, mem_addr, mem_wdata);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input bit wr, input bit wd, input bit sg, input logic [15:0] a,
                      input logic [15:0] d, output int t_acc, output int waited);
    resp_t r;
    wr_t   w;
    int    nb;
    logic [7:0] lo, hi;
    req_valid  = 1'b1;
    req_write  = wr;
    req_word   = wd;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = d;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready 0 after %0d cycles, required 1", waited);
      t_acc = -1;
      return;
    end
    t_acc = cyc;
    nb = wd ? 2 : 1;
    if (!wr) begin
      lo = ref_mem[a];
      hi = ref_mem[16'(a + 1)];
      r.data = wd ? {hi, lo} : (sg ? {{8{lo[7]}}, lo} : {8'h00, lo});
      r.cyc  = t_acc + nb * RL + 1;
    end else begin
      for (int k = 0; k < nb; k++) begin
        w.addr = 16'(a + k);
        w.data = d[8*k +: 8];
        w.cyc  = t_acc + (k + 1) * (WS + 1);
        ref_mem[w.addr] = w.data;
        wq.push_back(w);
      end
      r.data = '0;
      r.cyc  = t_acc + nb * (WS + 1) + 1;
    end
    rq.push_back(r);
    $display("req   cycle %0d %s %s addr %h wdata %h signed %0d", t_acc,
             wr ? "store" : "load ", wd ? "word" : "byte", a, d, sg);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  req_ready,  1);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_mem_addr"},   mem_addr,   0);
    chk({tag, "_mem_wdata"},  mem_wdata,  0);
    chk({tag, "_mem_write"},  mem_write,  0);
  endtask

  initial begin
    int t1, t2, w1, w2, b;
    logic [7:0] saved;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    send(0, 0, 1, 16'h0011, 16'h0000, t1, w1); idle(4);
    send(0, 0, 0, 16'h0011, 16'h0000, t1, w1); idle(4);
    send(0, 1, 0, 16'h0101, 16'h0000, t1, w1); idle(6);
    send(1, 0, 0, 16'h0020, 16'h77AB, t1, w1); idle(6);
    send(0, 1, 0, 16'h0020, 16'h0000, t1, w1); idle(6);
    send(1, 1, 0, 16'hFFFF, 16'hBEEF, t1, w1); idle(10);
    send(0, 1, 0, 16'hFFFF, 16'h0000, t1, w1); idle(6);

    // Back-to-back with req_valid held high
    send(0, 0, 0, 16'h0101, 16'h0000, t1, w1);
    send(0, 0, 1, 16'h0102, 16'h0000, t2, w2);
    chk("b2b_accept_gap", t2 - t1, 4);
    chk("b2b_ready_low_cycles", w2, 3);
    idle(6);

    // Reset while the store is in its setup phase
    saved = ref_mem[16'h0030];
    send(1, 0, 0, 16'h0030, 16'h00C3, t1, w1);
    rst_n = 1'b0;
    rq.delete();
    wq.delete();
    ref_mem[16'h0030] = saved;
    req_valid = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    repeat (3) begin
      @(negedge clk);
      chk("reset_no_write", mem_write, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 0, 0, 16'h0030, 16'h0000, t1, w1); idle(5);

    // Randomized traffic over a small address pool so loads see earlier stores
    repeat (300) begin
      case ($urandom_range(0, 3))
        0:       a = 16'hFFFF - 16'($urandom_range(0, 1));
        1:       a = 16'($urandom_range(0, 3));
        2:       a = 16'h0040 + 16'($urandom_range(0, 7));
        default: a = 16'($urandom);
      endcase
      send($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           a, 16'($urandom), t1, w1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(2);
    b = 0;
    while ((rq.size() != 0 || wq.size() != 0) && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk("pending_responses", rq.size(), 0);
    chk("pending_writes", wq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no completion by time limit, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for the byte-wide data port of the shared dual-port BSRAM memory block.
- Converts 8-bit and 16-bit load/store requests into sequenced byte accesses. Holds each address stable long enough to cover the memory's registered read path and its read-merge-write path.
- Sits between the core's execute stage and the memory's data port. The instruction port is untouched.

Parameters:
- READ_LATENCY, 2, cycles between mem_addr becoming stable and mem_rdata being valid for that address.
- WRITE_SETUP, 3, cycles mem_addr is held stable before mem_write is pulsed. Must be ≥ READ_LATENCY+1 because the memory merges the byte into a registered copy of the old word.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle; the request is accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_word  in  1  1 = 16-bit access, 0 = 8-bit access
- req_signed  in  1  sign-extend byte loads
- req_addr  in  16  byte address
- req_wdata  in  16  store data; byte stores use [7:0]
- resp_valid  out  1  one-cycle completion pulse, for both loads and stores
- resp_rdata  out  16  load result, valid while resp_valid is high
- mem_addr  out  16  to memory data_addr
- mem_wdata  out  8  to memory data_in
- mem_rdata  in  8  from memory data_out
- mem_write  out  1  to memory data_write

Behaviour:
- Reset (asynchronous, reset low):
  - State = IDLE.
  - req_ready = 1.
  - resp_valid = 0, resp_rdata = 0.
  - mem_addr = 0, mem_wdata = 0, mem_write = 0.
  - A reset mid-operation abandons the access: no resp_valid, and mem_write drops immediately.
- Request capture: req_ready = (state == IDLE), combinational from the state register. On acceptance, addr/wdata/write/word/signed are registered and the byte index is set to 0.
- Byte order: little-endian. Byte 0 is at addr, byte 1 at addr+1. The address wraps modulo 2^16 (0xFFFF+1 = 0x0000). Odd-aligned words are legal.
- FSM states: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, RESP.
  - IDLE → RD_WAIT on accepting a load.
  - IDLE → WR_SETUP on accepting a store.
  - RD_WAIT: mem_addr holds for READ_LATENCY cycles. mem_rdata is captured into resp_rdata[8*idx +: 8] on the edge ending the last wait cycle.
  - WR_SETUP: mem_wdata = byte idx of the store data, held for WRITE_SETUP cycles.
  - WR_PULSE: mem_write = 1 for exactly one cycle, with mem_addr and mem_wdata unchanged.
  - After byte 0 of a word access: idx ← 1, mem_addr ← addr+1, then re-enter RD_WAIT or WR_SETUP.
  - Otherwise the FSM goes to RESP.
  - RESP: resp_valid = 1 for one cycle, then IDLE. mem_addr keeps its last value; mem_write = 0.
- Load result:
  - Byte load: resp_rdata = {8{b[7]}, b} when req_signed, else {8'h00, b}.
  - Word load: req_signed is ignored.
  - Store: resp_rdata = 0.
- Latency, with acceptance in cycle T and default parameters:
  - Byte load: resp_valid in cycle T+READ_LATENCY+1 = T+3.
  - Word load: T+2·READ_LATENCY+1 = T+5.
  - Byte store: mem_write in cycle T+WRITE_SETUP+1 = T+4; resp_valid at T+5.
  - Word store: mem_write at T+4 and T+8; resp_valid at T+9.
- Back-to-back: a new request can be accepted in the cycle after RESP; no bubble beyond that.
- req_valid while busy is ignored; the requester must hold it.
- mem_write is never asserted unless mem_addr has been stable for ≥ WRITE_SETUP cycles.

Decomposition:
- Package lsu_pkg holds:
  - typedef lsu_state_t (enum of the five states)
  - constants DEFAULT_READ_LATENCY and DEFAULT_WRITE_SETUP
- One sub-module, lsu_wait_counter:
  - Loadable down-counter with width $clog2(max(READ_LATENCY, WRITE_SETUP)+1).
  - Inputs: load, load value. Output: done.
  - Uses the same asynchronous active-low reset.

Test Plan:
- Signed byte load: memory[0x0011] = 0x80, load byte addr 0x0011 with req_signed=1 → resp_valid at T+3, resp_rdata = 0xFF80. Repeat with req_signed=0 → 0x0080.
- Word load, odd address: memory[0x0101] = 0x34, memory[0x0102] = 0x12 → mem_addr is 0x0101 then 0x0102; resp_rdata = 0x1234 at T+5.
- Byte store: store 0xAB to 0x0020 whose word is 0x5566 → mem_write is a single pulse at T+4 with mem_addr = 0x0020; later word load of 0x0020 → 0x55AB, neighbour byte intact.
- Word store wrapping: store 0xBEEF to 0xFFFF → writes 0xEF@0xFFFF, then 0xBE@0x0000; two mem_write pulses at T+4 and T+8; resp_valid at T+9.
- Busy and back-to-back: req_valid held high across two loads → req_ready low from T+1 to T+3; second request accepted at T+4; no duplicate responses.
- Reset during WR_SETUP of a store → mem_write never pulses, no resp_valid, all outputs at reset values; the next request completes normally.
